greater_than_serial: RTL

GREATER_THAN_SERIAL -- requirements
Module: greater_than_serial

---
 rtl/cmp_pkg.sv | 19 +
 rtl/greater_than_serial.sv | 95 +++++++++
 2 files changed

// File: rtl/cmp_pkg.sv
// Shared types for the serial magnitude comparator: FSM states and result flags.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } cmp_state_t;

    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } cmp_result_t;

    localparam cmp_result_t RES_CLEAR = '{gt: 1'b0, eq: 1'b0, lt: 1'b0};
    localparam cmp_result_t RES_EQUAL = '{gt: 1'b0, eq: 1'b1, lt: 1'b0};

endpackage

// File: rtl/greater_than_serial.sv
// Bit-serial comparator of two WIDTH-bit operands; MSB-first by default,
// LSB-first when CMP_LSB_FIRST_EN is defined.
module greater_than_serial
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic bit_valid,
    input  logic a_bit,
    input  logic b_bit,
    output logic busy,
    output logic done,
    output logic gt,
    output logic eq,
    output logic lt
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

    cmp_state_t       r_state;
    cmp_state_t       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    cmp_result_t      r_res;
    cmp_result_t      w_res_next;
    logic             w_diff;

    assign w_diff = a_bit ^ b_bit;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_res_next   = r_res;
        case (r_state)
            IDLE: begin
                // Bits presented alongside start are deliberately not sampled.
                if (start) begin
                    w_state_next = SHIFT;
                    w_cnt_next   = '0;
                    w_res_next   = RES_EQUAL;
                end
            end
            SHIFT: begin
                if (bit_valid) begin
                    if (r_cnt != CNT_FULL) begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
`ifdef CMP_LSB_FIRST_EN
                    // Later bits are more significant, so the last difference wins.
                    if (w_diff) begin
                        w_res_next = '{gt: a_bit, eq: 1'b0, lt: b_bit};
                    end
`else
                    if (w_diff && r_res.eq) begin
                        w_res_next = '{gt: a_bit, eq: 1'b0, lt: b_bit};
                    end
`endif
                    if (r_cnt == CNT_LAST) begin
                        w_state_next = DONE;
                    end
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_res   <= RES_CLEAR;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_res   <= w_res_next;
        end
    end

    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);
    assign gt   = r_res.gt;
    assign eq   = r_res.eq;
    assign lt   = r_res.lt;

endmodule
